// File: rtl/piso_tx.sv
// piso_tx: parallel-in/serial-out transmitter with valid/ready load and a
// per-bit enable strobe, one bit every DIV clocks.
//
// Ports:
//   piso_port_clk         - system clock, rising edge
//   piso_port_rst         - asynchronous reset, active low
//   piso_port_load_valid  - source offers piso_port_data
//   piso_port_data        - WIDTH-bit word to send
//   piso_oport_load_ready - high in IDLE; word accepted on valid && ready
//   piso_oport_d          - serial data bit (0 outside SHIFT)
//   piso_oport_en         - strobe on the first cycle of each bit period
//   piso_oport_busy       - high while the word is being shifted
//   piso_oport_done       - one-cycle pulse after the last bit period
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter int DIV       = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             piso_port_clk,
    input  logic             piso_port_rst,
    input  logic             piso_port_load_valid,
    input  logic [WIDTH-1:0] piso_port_data,
    output logic             piso_oport_load_ready,
    output logic             piso_oport_d,
    output logic             piso_oport_en,
    output logic             piso_oport_busy,
    output logic             piso_oport_done
);

    localparam int BW = $clog2(WIDTH);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [DW-1:0]    div_q, div_d;
    logic             d_q, d_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic accept;
    logic bit_end;
    logic last;

    assign accept  = (state_q == S_IDLE) && piso_port_load_valid;
    assign bit_end = (div_q == DIV_LAST);
    assign last    = (state_q == S_SHIFT) && bit_end && (bit_q == BIT_LAST);

    // Bit on the line next, and the remaining bits after removing it.
    function automatic logic head(input logic [WIDTH-1:0] x);
        return (MSB_FIRST != 0) ? x[WIDTH-1] : x[0];
    endfunction

    function automatic logic [WIDTH-1:0] tail(input logic [WIDTH-1:0] x);
        return (MSB_FIRST != 0) ? {x[WIDTH-2:0], 1'b0}
                                : {1'b0, x[WIDTH-1:1]};
    endfunction

    always_ff @(posedge piso_port_clk or negedge piso_port_rst) begin
        if (!piso_port_rst) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            d_q     <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            d_q     <= d_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = S_SHIFT;
            S_SHIFT: if (last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered, so each branch computes what the line shows
    // during the cycle after the current edge.
    always_comb begin
        sr_d   = sr_q;
        bit_d  = bit_q;
        div_d  = div_q;
        d_d    = 1'b0;
        en_d   = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    sr_d   = tail(piso_port_data);
                    d_d    = head(piso_port_data);
                    en_d   = 1'b1;
                    busy_d = 1'b1;
                    bit_d  = '0;
                    div_d  = '0;
                end
            end
            S_SHIFT: begin
                if (last) begin
                    done_d = 1'b1;
                    sr_d   = '0;
                    bit_d  = '0;
                    div_d  = '0;
                end else begin
                    busy_d = 1'b1;
                    if (bit_end) begin
                        div_d = '0;
                        bit_d = bit_q + BW'(1);
                        en_d  = 1'b1;
                        d_d   = head(sr_q);
                        sr_d  = tail(sr_q);
                    end else begin
                        div_d = div_q + DW'(1);
                        d_d   = d_q;
                    end
                end
            end
            S_DONE: begin
                bit_d = '0;
                div_d = '0;
            end
            default: begin
                sr_d  = '0;
                bit_d = '0;
                div_d = '0;
            end
        endcase
    end

    assign piso_oport_load_ready = (state_q == S_IDLE);
    assign piso_oport_d          = d_q;
    assign piso_oport_en         = en_q;
    assign piso_oport_busy       = busy_q;
    assign piso_oport_done       = done_q;

endmodule
